// File: rtl/dff_pipe_pkg.sv
// Shared types, defaults and helpers for the dff_pipe retiming/buffer pipeline.
// DFF_PIPE_PARITY_EN (optional) adds a stored parity bit per stage and a sticky par_err output.
package dff_pipe_pkg;

  localparam int DFF_PIPE_WIDTH = 8;
  localparam int DFF_PIPE_DEPTH = 4;
  localparam int PAR_MAX_W      = 64;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Callers zero-extend into PAR_MAX_W bits; zero padding leaves the parity unchanged.
  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// One pipeline stage: data + valid registers with async reset, sync clear and load enable.
// Data only loads when the incoming word is valid, so an emptied stage keeps its last value.
module dff_pipe_stage
  import dff_pipe_pkg::*;
#(
  parameter int           W       = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] d_data,
  input  logic         d_valid,
  output logic [W-1:0] q_data,
  output logic         q_valid
);

  logic [W-1:0] data_d, data_q;
  logic         valid_d, valid_q;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (clear) begin
      data_d  = RST_VAL;
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = d_valid;
      if (d_valid) data_d = d_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_q  <= RST_VAL;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign q_data  = data_q;
  assign q_valid = valid_q;

endmodule

// File: rtl/dff_pipe.sv
// Bubble-collapsing valid/ready register pipeline, WIDTH bits by DEPTH stages.
// Optional DFF_PIPE_PARITY_EN: even-parity bit per stage and sticky par_err output.
module dff_pipe
  import dff_pipe_pkg::*;
#(
  parameter int               WIDTH       = DFF_PIPE_WIDTH,
  parameter int               DEPTH       = DFF_PIPE_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    clear,
  input  logic [WIDTH-1:0]        in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [cnt_w(DEPTH)-1:0] count
`ifdef DFF_PIPE_PARITY_EN
  ,
  output logic                    par_err
`endif
);

  localparam int CW = cnt_w(DEPTH);
`ifdef DFF_PIPE_PARITY_EN
  localparam int SW = WIDTH + 1;
  localparam logic [SW-1:0] RST_W = {even_parity(PAR_MAX_W'(RESET_VALUE)), RESET_VALUE};
`else
  localparam int SW = WIDTH;
  localparam logic [SW-1:0] RST_W = RESET_VALUE;
`endif

  logic [DEPTH-1:0]          move, vld, vin;
  logic [DEPTH-1:0][SW-1:0]  dat, din;
  logic [SW-1:0]             in_word;
  logic                      push, pop;
  logic [CW-1:0]             count_d, count_q;

`ifdef DFF_PIPE_PARITY_EN
  assign in_word = {even_parity(PAR_MAX_W'(in_data)), in_data};
`else
  assign in_word = in_data;
`endif

  // Ready ripples from the output back to the input; a stage moves if empty or its successor moves.
  always_comb begin
    move = '0;
    move[DEPTH-1] = !vld[DEPTH-1] | out_ready;
    for (int k = DEPTH - 2; k >= 0; k--) move[k] = !vld[k] | move[k+1];
  end

  assign in_ready = move[0];
  assign push     = in_valid & in_ready;
  assign pop      = vld[DEPTH-1] & out_ready;

  always_comb begin
    din    = '0;
    vin    = '0;
    din[0] = in_word;
    vin[0] = push;
    for (int k = 1; k < DEPTH; k++) begin
      din[k] = dat[k-1];
      vin[k] = vld[k-1];
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    dff_pipe_stage #(.W(SW), .RST_VAL(RST_W)) u_stage (
      .clock   (clock),
      .reset   (reset),
      .clear   (clear),
      .load    (move[k]),
      .d_data  (din[k]),
      .d_valid (vin[k]),
      .q_data  (dat[k]),
      .q_valid (vld[k])
    );
  end

  always_comb begin
    count_d = count_q;
    if (clear) count_d = '0;
    else       count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count     = count_q;
  assign out_valid = vld[DEPTH-1];
  assign out_data  = dat[DEPTH-1][WIDTH-1:0];

`ifdef DFF_PIPE_PARITY_EN
  logic par_err_d, par_err_q;

  always_comb begin
    par_err_d = par_err_q;
    if (clear) par_err_d = 1'b0;
    else if (out_valid && (even_parity(PAR_MAX_W'(out_data)) != dat[DEPTH-1][WIDTH]))
      par_err_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) par_err_q <= 1'b0;
    else        par_err_q <= par_err_d;
  end

  assign par_err = par_err_q;
`endif

endmodule

// File: tb/tb_dff_pipe.sv
// Scoreboard bench for dff_pipe (WIDTH=8, DEPTH=4): directed pushes feed an expected queue,
// a negedge monitor pops and compares on every output handshake.
module tb_dff_pipe;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [2:0] count;
`ifdef DFF_PIPE_PARITY_EN
  logic       par_err;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  always #5 clock = ~clock;

  dff_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VALUE(8'h00)) dut (
    .clock     (clock),
    .reset     (reset),
    .clear     (clear),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count)
`ifdef DFF_PIPE_PARITY_EN
    ,
    .par_err   (par_err)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  // Consumer side: every output handshake must match the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clock);
      if (reset && out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_out", {24'h0, out_data}, 32'hffff_ffff);
        else                   chk("out_data", {24'h0, out_data}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  // One clock: optional pre-edge in_ready check, record the push, land 1ns after the edge.
  task automatic step(input bit ck, input bit er, input string nm);
    @(negedge clock);
    if (ck) chk(nm, {31'h0, in_ready}, {31'h0, er});
    if (in_valid && in_ready && !clear && reset) exp_q.push_back(in_data);
    @(posedge clock);
    #1;
    if (clear) exp_q.delete();
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((out_valid || exp_q.size() != 0) && n < 20) begin
      step(0, 0, "");
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
    chk("drain_count", {29'h0, count}, 0);
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_valid", {31'h0, out_valid}, 0);
    chk("rst_count", {29'h0, count}, 0);
    chk("rst_data", {24'h0, out_data}, 0);
`ifdef DFF_PIPE_PARITY_EN
    chk("rst_par_err", {31'h0, par_err}, 0);
`endif
    #20 reset = 1'b1;
    @(posedge clock); #1;

    // Latency through an empty pipe
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'hA5;
    step(1, 1, "lat_rdy");
    in_valid = 1'b0;
    chk("lat_count0", {29'h0, count}, 1);
    chk("lat_valid0", {31'h0, out_valid}, 0);
    for (int e = 1; e <= 3; e++) begin
      step(0, 0, "");
      chk("lat_count", {29'h0, count}, 1);
      chk("lat_valid", {31'h0, out_valid}, (e == 3) ? 1 : 0);
    end
    chk("lat_data", {24'h0, out_data}, 32'hA5);
    step(0, 0, "");
    chk("lat_count_pop", {29'h0, count}, 0);
    chk("lat_valid_pop", {31'h0, out_valid}, 0);
    chk("empty_hold", {24'h0, out_data}, 32'hA5);

    // Backpressure fill, then release
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      in_data = 8'(i);
      step(1, (i <= 4), "bp_rdy");
    end
    in_valid = 1'b0;
    chk("bp_count", {29'h0, count}, 4);
    chk("bp_data", {24'h0, out_data}, 32'h01);
    drain();

    // Full pipe with simultaneous push and pop
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'h10 + 8'(i);
      step(0, 0, "");
    end
    chk("full_count", {29'h0, count}, 4);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = 8'h20 + 8'(i);
      step(1, 1, "full_rdy");
      chk("full_count_pp", {29'h0, count}, 4);
    end
    drain();

    // Clear beats a same-cycle push and pop
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'h30 + 8'(i);
      step(0, 0, "");
    end
    chk("clr_pre_count", {29'h0, count}, 3);
    in_data   = 8'h33;
    out_ready = 1'b1;
    clear     = 1'b1;
    step(0, 0, "");
    clear    = 1'b0;
    in_valid = 1'b0;
    chk("clr_count", {29'h0, count}, 0);
    chk("clr_valid", {31'h0, out_valid}, 0);
    chk("clr_data", {24'h0, out_data}, 0);
    for (int i = 0; i < 6; i++) step(0, 0, "");
    chk("clr_still_empty", {31'h0, out_valid}, 0);

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h11;
    step(0, 0, "");
    in_data = 8'h22;
    step(0, 0, "");
    in_valid = 1'b0;
    step(0, 0, "");
    step(0, 0, "");
    chk("ar_pre_valid", {31'h0, out_valid}, 1);
    chk("ar_pre_data", {24'h0, out_data}, 32'h11);
    #2 reset = 1'b0;
    #1;
    chk("ar_valid", {31'h0, out_valid}, 0);
    chk("ar_count", {29'h0, count}, 0);
    chk("ar_data", {24'h0, out_data}, 0);
    exp_q.delete();
    @(posedge clock); #2;
    reset = 1'b1;
    @(posedge clock); #1;

`ifdef DFF_PIPE_PARITY_EN
    // Corrupt the output stage and expect a sticky parity error
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h5A;
    step(0, 0, "");
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) step(0, 0, "");
    chk("par_pre", {31'h0, par_err}, 0);
    force dut.g_stage[3].u_stage.data_q = 9'h05B;
    @(posedge clock); #1;
    release dut.g_stage[3].u_stage.data_q;
    chk("par_set", {31'h0, par_err}, 1);
    step(0, 0, "");
    step(0, 0, "");
    chk("par_sticky", {31'h0, par_err}, 1);
    clear = 1'b1;
    step(0, 0, "");
    clear = 1'b0;
    chk("par_clr", {31'h0, par_err}, 0);
`endif

    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
